// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the program-counter / fetch-sequencing stage.
// Holds the state enum, the width defaults and the branch-target table.
package pc_unit_pkg;

    localparam int PC_W_DEFAULT      = 10;
    localparam int LUT_IDX_W_DEFAULT = 5;
    localparam int LUT_DEPTH         = 2 ** LUT_IDX_W_DEFAULT;
    localparam int CYCLES_W          = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_e;

    // Entries are two's complement; they are absolute targets for jumps and offsets for branches.
    localparam logic [PC_W_DEFAULT-1:0] BR_LUT [LUT_DEPTH] = '{
        10'd0, 10'd0, 10'd0, 10'h3FC, 10'd0, 10'd100, 10'd0, 10'd0,
        10'd0, 10'd0, 10'd0, 10'd0,   10'd0, 10'd0,   10'd0, 10'd0,
        10'd0, 10'd0, 10'd0, 10'd0,   10'd0, 10'd0,   10'd0, 10'd0,
        10'd0, 10'd0, 10'd0, 10'd0,   10'd0, 10'd0,   10'd0, 10'd0
    };

    function automatic logic [CYCLES_W-1:0] sat_inc(input logic [CYCLES_W-1:0] value);
        if (value == {CYCLES_W{1'b1}}) begin
            return value;
        end
        return value + CYCLES_W'(1);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the decoder/testbench side (master) and pc_unit (slave).
interface pc_unit_if
    import pc_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int LUT_IDX_W = LUT_IDX_W_DEFAULT
);

    logic                 start;
    logic [PC_W-1:0]      start_addr;
    logic                 halt;
    logic                 stall;
    logic                 br_en;
    logic                 branch;
    logic                 jump;
    logic [LUT_IDX_W-1:0] lut_idx;

    logic [PC_W-1:0]      pc;
    logic                 running;
    logic                 done;
    logic [CYCLES_W-1:0]  cycles;

    modport master (
        output start, start_addr, halt, stall, br_en, branch, jump, lut_idx,
        input  pc, running, done, cycles
    );

    modport slave (
        input  start, start_addr, halt, stall, br_en, branch, jump, lut_idx,
        output pc, running, done, cycles
    );

endinterface

// File: rtl/pc_unit_branch_lut.sv
// Combinational branch-target lookup, kept on its own so the assembler can regenerate it.
module branch_lut
    import pc_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int LUT_IDX_W = LUT_IDX_W_DEFAULT
) (
    input  logic [LUT_IDX_W-1:0] lut_idx_i,
    output logic [PC_W-1:0]      target_o
);

    // Sign-extend (or truncate) the table entry so offsets stay correct for any PC width.
    always_comb begin
        target_o = '0;
        for (int k = 0; k < LUT_DEPTH; k++) begin
            if (32'(lut_idx_i) == k) begin
                target_o = PC_W'($signed(BR_LUT[k]));
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter and fetch sequencer: IDLE -> RUN -> DONE with start/halt handshake.
// Optional executed-cycle counter enabled by defining PC_UNIT_CYCLE_COUNT_EN.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int LUT_IDX_W = LUT_IDX_W_DEFAULT
) (
    input  logic    clk_i,
    input  logic    rst_i,
    pc_unit_if.slave bus
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] lut_target;

    branch_lut #(
        .PC_W      (PC_W),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_branch_lut (
        .lut_idx_i (bus.lut_idx),
        .target_o  (lut_target)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // BRANCH arrives combinationally from the ALU in the same cycle as the PC it qualifies.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = bus.start_addr;
                end
            end
            RUN: begin
                if (bus.start) begin
                    pc_d = bus.start_addr;
                end else if (bus.halt) begin
                    state_d = DONE;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.jump) begin
                    pc_d = lut_target;
                end else if (bus.br_en && bus.branch) begin
                    pc_d = pc_q + lut_target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign bus.pc      = pc_q;
    assign bus.running = (state_q == RUN);
    assign bus.done    = (state_q == DONE);

`ifdef PC_UNIT_CYCLE_COUNT_EN
    logic [CYCLES_W-1:0] cycles_q, cycles_d;

    // Every edge spent in RUN counts, including the halting edge; START restarts from zero.
    always_comb begin
        cycles_d = cycles_q;
        if (bus.start) begin
            cycles_d = '0;
        end else if (state_q == RUN) begin
            cycles_d = sat_inc(cycles_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign bus.cycles = cycles_q;
`else
    assign bus.cycles = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_unit;
    import pc_unit_pkg::*;

    localparam int PW     = 10;
    localparam int IW     = 5;
    localparam int PC_MOD = 1 << PW;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int mPc;
    bit mRunning;
    bit mDone;
    int mCycles;

    pc_unit_if #(.PC_W(PW), .LUT_IDX_W(IW)) bus ();

    pc_unit #(.PC_W(PW), .LUT_IDX_W(IW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int lutOffset(input int idx);
        case (idx)
            3:       return -4;
            5:       return 100;
            default: return 0;
        endcase
    endfunction

    function automatic int wrapPc(input int value);
        return ((value % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    task automatic modelReset();
        mPc      = 0;
        mRunning = 0;
        mDone    = 0;
        mCycles  = 0;
    endtask

    task automatic modelStep(input bit st, input int sa, input bit hlt, input bit stl,
                             input bit jmp, input bit be, input bit br, input int idx);
        if (!mRunning) begin
            if (st) begin
                mRunning = 1;
                mDone    = 0;
                mPc      = sa;
                mCycles  = 0;
            end
        end else if (st) begin
            mPc     = sa;
            mCycles = 0;
        end else begin
`ifdef PC_UNIT_CYCLE_COUNT_EN
            if (mCycles < 65535) mCycles++;
`endif
            if (hlt) begin
                mRunning = 0;
                mDone    = 1;
            end else if (stl) begin
                mPc = mPc;
            end else if (jmp) begin
                mPc = wrapPc(lutOffset(idx));
            end else if (be && br) begin
                mPc = wrapPc(mPc + lutOffset(idx));
            end else begin
                mPc = wrapPc(mPc + 1);
            end
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "/pc"}, 32'(bus.pc), mPc);
        checkOutput({tag, "/running"}, 32'(bus.running), 32'(mRunning));
        checkOutput({tag, "/done"}, 32'(bus.done), 32'(mDone));
        checkOutput({tag, "/cycles"}, 32'(bus.cycles), mCycles);
    endtask

    // Drive at the falling edge, let the DUT take the rising edge, then compare at the next falling edge.
    task automatic applyStimulus(input string tag, input bit st, input int sa, input bit hlt,
                                 input bit stl, input bit jmp, input bit be, input bit br, input int idx);
        bus.start      = st;
        bus.start_addr = PW'(sa);
        bus.halt       = hlt;
        bus.stall      = stl;
        bus.jump       = jmp;
        bus.br_en      = be;
        bus.branch     = br;
        bus.lut_idx    = IW'(idx);
        @(posedge clk);
        modelStep(st, sa, hlt, stl, jmp, be, br, idx);
        @(negedge clk);
        checkModel(tag);
    endtask

    task automatic idleStep(input string tag);
        applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic startAt(input string tag, input int addr);
        applyStimulus(tag, 1, addr, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int expCycles;
        rst = 1'b1;
        bus.start = 0; bus.start_addr = '0; bus.halt = 0; bus.stall = 0;
        bus.jump = 0; bus.br_en = 0; bus.branch = 0; bus.lut_idx = '0;
        modelReset();
        repeat (2) @(negedge clk);
        checkModel("reset");
        rst = 1'b0;

        idleStep("idleNoStart");
        startAt("start0", 0);
        checkOutput("startPc", 32'(bus.pc), 0);
        checkOutput("startRunning", 32'(bus.running), 1);
        for (int i = 0; i < 3; i++) idleStep("freeRun");
        checkOutput("freeRun3", 32'(bus.pc), 3);

        startAt("start20", 20);
        applyStimulus("brTaken", 0, 0, 0, 0, 0, 1, 1, 3);
        checkOutput("brTakenPc", 32'(bus.pc), 16);
        startAt("start20b", 20);
        applyStimulus("brNotTaken", 0, 0, 0, 0, 0, 1, 0, 3);
        checkOutput("brNotTakenPc", 32'(bus.pc), 21);
        applyStimulus("brNoEnable", 0, 0, 0, 0, 0, 0, 1, 5);
        checkOutput("brNoEnablePc", 32'(bus.pc), 22);

        startAt("start7", 7);
        applyStimulus("jump", 0, 0, 0, 0, 1, 1, 1, 5);
        checkOutput("jumpPc", 32'(bus.pc), 100);
        startAt("start7b", 7);
        applyStimulus("jumpStall", 0, 0, 0, 1, 1, 0, 0, 5);
        checkOutput("jumpStallPc", 32'(bus.pc), 7);

        startAt("start40", 40);
        applyStimulus("halt", 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("haltPc", 32'(bus.pc), 40);
        checkOutput("haltDone", 32'(bus.done), 1);
        checkOutput("haltRunning", 32'(bus.running), 0);
        applyStimulus("doneBranch", 0, 0, 0, 0, 0, 1, 1, 3);
        applyStimulus("doneJump", 0, 0, 1, 0, 1, 0, 0, 5);
        applyStimulus("doneStall", 0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("doneHoldPc", 32'(bus.pc), 40);
        checkOutput("doneHoldDone", 32'(bus.done), 1);
        startAt("restart0", 0);
        checkOutput("restartDone", 32'(bus.done), 0);
        checkOutput("restartPc", 32'(bus.pc), 0);

        startAt("start1023", 1023);
        idleStep("wrapInc");
        checkOutput("wrapIncPc", 32'(bus.pc), 0);
        startAt("start2", 2);
        applyStimulus("wrapBranch", 0, 0, 0, 0, 0, 1, 1, 3);
        checkOutput("wrapBranchPc", 32'(bus.pc), 1022);

        startAt("start50", 50);
        idleStep("preReset1");
        idleStep("preReset2");
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncPc", 32'(bus.pc), 0);
        checkOutput("asyncRunning", 32'(bus.running), 0);
        checkOutput("asyncDone", 32'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus("postResetNoise", 0, 9, 1, 1, 1, 1, 1, 5);
        idleStep("postResetIdle");

`ifdef PC_UNIT_CYCLE_COUNT_EN
        expCycles = 6;
`else
        expCycles = 0;
`endif
        startAt("cycStart", 0);
        idleStep("cycRun1");
        applyStimulus("cycStall1", 0, 0, 0, 1, 0, 0, 0, 0);
        idleStep("cycRun2");
        applyStimulus("cycStall2", 0, 0, 0, 1, 0, 0, 0, 0);
        idleStep("cycRun3");
        applyStimulus("cycHalt", 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("cyclesAtHalt", 32'(bus.cycles), expCycles);
        for (int i = 0; i < 3; i++) idleStep("cycDone");
        checkOutput("cyclesFrozen", 32'(bus.cycles), expCycles);

        for (int i = 0; i < 600; i++) begin
            bit st, hlt, stl, jmp, be, br;
            int idx;
            int pick;
            st   = mRunning ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
            hlt  = ($urandom_range(0, 24) == 0);
            stl  = ($urandom_range(0, 3) == 0);
            jmp  = ($urandom_range(0, 5) == 0);
            be   = ($urandom_range(0, 2) == 0);
            br   = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 3);
            idx  = (pick == 0) ? 3 : (pick == 1) ? 5 : (pick == 2) ? 0 : $urandom_range(0, 31);
            applyStimulus("random", st, $urandom_range(0, PC_MOD - 1), hlt, stl, jmp, be, br, idx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
